// File: rtl/mem_burst_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_burst_if                                          |
// | Brief    : request/response bundle for the mem_burst block       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface mem_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              par_flip;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, par_flip,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, par_flip,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_burst.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_burst                                             |
// | Brief    : single-port word memory with single-beat writes and   |
// |            wrapping read bursts behind a fixed-latency pipeline  |
// | Option   : MEM_BURST_PARITY_EN adds a per-word even-parity bit   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module mem_burst #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 3
) (
  input logic        clk,
  input logic        rst_n,
  mem_burst_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              w_ready;
  logic              w_issue;
  logic              w_wr_en;
  logic              w_rd_acc;
  logic              w_rd_err;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read pipeline: stage 0 is the memory read register, the last stage drives the outputs.
  logic              r_pv [RD_LAT];
  logic [DATA_W-1:0] r_pd [RD_LAT];
  logic              r_pl [RD_LAT];
  logic              r_pe [RD_LAT];

  assign w_wr_en  = bus.req_valid && w_ready && bus.req_write;
  assign w_rd_acc = bus.req_valid && w_ready && !bus.req_write;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: leave DRAIN once the final beat is on the outputs, so ready rises a cycle after rsp_last.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rd_acc) w_next = S_BURST;
      S_BURST: if (r_cnt == '0) w_next = S_DRAIN;
      S_DRAIN: if (r_pv[RD_LAT-1] && r_pl[RD_LAT-1]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs: accept only when idle, issue one read per BURST cycle.
  always_comb begin
    w_ready = (r_state == S_IDLE);
    w_issue = (r_state == S_BURST);
  end

  // Burst address/count: loaded on accept, stepped on every issued read; address wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_rd_acc) begin
      r_addr <= bus.req_addr;
      r_cnt  <= bus.req_len;
    end else if (w_issue) begin
      r_addr <= r_addr + 1'b1;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

`ifdef MEM_BURST_PARITY_EN
  logic r_par [DEPTH];

  // Storage with parity: the stored bit is inverted on request to model a corrupted word.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[bus.req_addr] <= bus.req_wdata;
      r_par[bus.req_addr] <= (^bus.req_wdata) ^ bus.par_flip;
    end
  end

  assign w_rd_err = (^r_mem[r_addr]) ^ r_par[r_addr];
`else
  logic w_unused_par;

  // Storage without parity; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[bus.req_addr] <= bus.req_wdata;
  end

  assign w_rd_err     = 1'b0;
  assign w_unused_par = bus.par_flip;
`endif

  // Read pipeline: valids shift every cycle, payload moves only with a valid so rsp_data holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pl[i] <= 1'b0;
        r_pe[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_issue;
      if (w_issue) begin
        r_pd[0] <= r_mem[r_addr];
        r_pl[0] <= (r_cnt == '0);
        r_pe[0] <= w_rd_err;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
          r_pl[i] <= r_pl[i-1];
          r_pe[i] <= r_pe[i-1];
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_pv[RD_LAT-1];
  assign bus.rsp_data  = r_pd[RD_LAT-1];
  assign bus.rsp_last  = r_pv[RD_LAT-1] && r_pl[RD_LAT-1];
  assign bus.rsp_err   = r_pv[RD_LAT-1] && r_pe[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_mem_burst.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_mem_burst                                          |
// | Brief    : self-checking bench, two instances (RD_LAT 1 and 3)   |
// |            against a transaction-level memory model              |
// | Option   : follows MEM_BURST_PARITY_EN like the design           |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_mem_burst;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
`ifdef MEM_BURST_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Per-instance stimulus and observed outputs, index 0 = RD_LAT 1, index 1 = RD_LAT 3.
  logic       t_valid [2];
  logic       t_write [2];
  logic [4:0] t_addr  [2];
  logic [2:0] t_len   [2];
  logic [7:0] t_wdata [2];
  logic       t_flip  [2];
  logic       o_ready [2];
  logic       o_valid [2];
  logic [7:0] o_data  [2];
  logic       o_last  [2];
  logic       o_err   [2];

  // Reference model: memory image, corrupted-parity flags, last delivered data.
  logic [7:0] mem_m     [2][32];
  bit         bad_m     [2][32];
  logic [7:0] last_data [2];

  int checks = 0;
  int errors = 0;

  mem_burst_if #(.DATA_W(8), .ADDR_W(5), .LEN_W(3)) bus0 ();
  mem_burst_if #(.DATA_W(8), .ADDR_W(5), .LEN_W(3)) bus1 ();

  assign bus0.req_valid = t_valid[0];
  assign bus0.req_write = t_write[0];
  assign bus0.req_addr  = t_addr[0];
  assign bus0.req_len   = t_len[0];
  assign bus0.req_wdata = t_wdata[0];
  assign bus0.par_flip  = t_flip[0];
  assign bus1.req_valid = t_valid[1];
  assign bus1.req_write = t_write[1];
  assign bus1.req_addr  = t_addr[1];
  assign bus1.req_len   = t_len[1];
  assign bus1.req_wdata = t_wdata[1];
  assign bus1.par_flip  = t_flip[1];

  assign o_ready[0] = bus0.req_ready;
  assign o_valid[0] = bus0.rsp_valid;
  assign o_data[0]  = bus0.rsp_data;
  assign o_last[0]  = bus0.rsp_last;
  assign o_err[0]   = bus0.rsp_err;
  assign o_ready[1] = bus1.req_ready;
  assign o_valid[1] = bus1.rsp_valid;
  assign o_data[1]  = bus1.rsp_data;
  assign o_last[1]  = bus1.rsp_last;
  assign o_err[1]   = bus1.rsp_err;

  mem_burst #(.DATA_W(8), .ADDR_W(5), .RD_LAT(LAT0), .LEN_W(3)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mem_burst #(.DATA_W(8), .ADDR_W(5), .RD_LAT(LAT1), .LEN_W(3)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Single-beat write; the block must stay ready and produce no response.
  task automatic do_write(input int d, input int addr, input logic [7:0] data, input bit flip);
    checks++;
    if (o_ready[d] !== 1'b1) begin
      errors++; $display("FAIL wr_ready_pre d=%0d got %b exp 1", d, o_ready[d]);
    end
    t_valid[d] = 1'b1; t_write[d] = 1'b1; t_addr[d] = 5'(addr);
    t_wdata[d] = data; t_flip[d] = flip; t_len[d] = 3'($urandom);
    @(posedge clk); #1;
    mem_m[d][addr] = data;
    bad_m[d][addr] = flip;
    t_valid[d] = 1'b0;
    checks++;
    if (o_ready[d] !== 1'b1) begin
      errors++; $display("FAIL wr_ready_post d=%0d got %b exp 1", d, o_ready[d]);
    end
    checks++;
    if (o_valid[d] !== 1'b0) begin
      errors++; $display("FAIL wr_no_rsp d=%0d got %b exp 0", d, o_valid[d]);
    end
  endtask

  // Read burst, checked cycle by cycle from the accept edge; hold keeps req_valid high with junk
  // during the burst; rst_at >= 0 pulls reset while that beat index is on the outputs.
  task automatic do_read(input int d, input int addr, input int len, input bit hold, input int rst_at);
    int lat;
    int beat;
    int a;
    bit ev, el, ee, er;
    logic [7:0] ed;
    lat = (d == 0) ? LAT0 : LAT1;
    checks++;
    if (o_ready[d] !== 1'b1) begin
      errors++; $display("FAIL rd_ready_pre d=%0d got %b exp 1", d, o_ready[d]);
    end
    t_valid[d] = 1'b1; t_write[d] = 1'b0; t_addr[d] = 5'(addr); t_len[d] = 3'(len);
    @(posedge clk); #1;
    for (int c = 0; c <= lat + len + 1; c++) begin
      beat = c - lat;
      a    = (addr + beat + 32) % 32;
      ev   = (c >= lat) && (c <= lat + len);
      if (ev) last_data[d] = mem_m[d][a];
      ed = last_data[d];
      el = ev && (beat == len);
      ee = ev && PAR && bad_m[d][a];
      er = (c == lat + len + 1);
      checks++;
      if (o_valid[d] !== ev) begin
        errors++; $display("FAIL rd_valid d=%0d c=%0d got %b exp %b", d, c, o_valid[d], ev);
      end
      checks++;
      if (o_data[d] !== ed) begin
        errors++; $display("FAIL rd_data d=%0d c=%0d got %h exp %h", d, c, o_data[d], ed);
      end
      checks++;
      if (o_last[d] !== el) begin
        errors++; $display("FAIL rd_last d=%0d c=%0d got %b exp %b", d, c, o_last[d], el);
      end
      checks++;
      if (o_err[d] !== ee) begin
        errors++; $display("FAIL rd_err d=%0d c=%0d got %b exp %b", d, c, o_err[d], ee);
      end
      checks++;
      if (o_ready[d] !== er) begin
        errors++; $display("FAIL rd_ready d=%0d c=%0d got %b exp %b", d, c, o_ready[d], er);
      end
      if (ev && (beat == rst_at)) begin
        t_valid[d] = 1'b0;
        rst_n = 1'b0;
        #1;
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        checks++;
        if ({o_valid[d], o_last[d], o_err[d], o_data[d]} !== 11'h0) begin
          errors++; $display("FAIL rst_async d=%0d got v%b l%b e%b %h exp all 0",
                             d, o_valid[d], o_last[d], o_err[d], o_data[d]);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          checks++;
          if (o_valid[d] !== 1'b0 || o_ready[d] !== 1'b1) begin
            errors++; $display("FAIL rst_quiet d=%0d k=%0d got v%b r%b exp v0 r1",
                               d, k, o_valid[d], o_ready[d]);
          end
        end
        return;
      end
      if (c == lat + len + 1) begin
        t_valid[d] = 1'b0;
      end else if (hold) begin
        t_valid[d] = 1'b1; t_write[d] = 1'($urandom); t_addr[d] = 5'($urandom);
        t_len[d] = 3'($urandom); t_wdata[d] = 8'($urandom); t_flip[d] = 1'($urandom);
      end else begin
        t_valid[d] = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      t_valid[d] = 1'b0; t_write[d] = 1'b0; t_addr[d] = '0;
      t_len[d] = '0; t_wdata[d] = '0; t_flip[d] = 1'b0;
      last_data[d] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_valid[d], o_last[d], o_err[d], o_data[d]} !== 11'h0) begin
        errors++; $display("FAIL reset_outputs d=%0d got v%b l%b e%b %h exp all 0",
                           d, o_valid[d], o_last[d], o_err[d], o_data[d]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_ready[d] !== 1'b1 || o_valid[d] !== 1'b0) begin
        errors++; $display("FAIL reset_release d=%0d got r%b v%b exp r1 v0", d, o_ready[d], o_valid[d]);
      end
    end
  endtask

  task automatic test_fill();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) do_write(d, a, 8'($urandom), 1'b0);
  endtask

  task automatic test_single_read();
    for (int d = 0; d < 2; d++) begin
      do_write(d, 3, 8'hA5, 1'b0);
      do_read(d, 3, 0, 1'b0, -1);
    end
  endtask

  task automatic test_wrap();
    for (int d = 0; d < 2; d++) begin
      do_write(d, 30, 8'h11, 1'b0);
      do_write(d, 31, 8'h22, 1'b0);
      do_write(d, 0,  8'h33, 1'b0);
      do_write(d, 1,  8'h44, 1'b0);
      do_read(d, 30, 3, 1'b0, -1);
    end
  endtask

  task automatic test_long_burst();
    do_read(1, 20, 7, 1'b1, -1);
    do_read(0, 5, 7, 1'b1, -1);
    do_read(1, 20, 7, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    int a;
    for (int n = 0; n < 6; n++) begin
      a = $urandom_range(0, 31);
      do_write(n % 2, a, 8'($urandom), 1'b0);
      do_read(n % 2, a, $urandom_range(0, 7), 1'b0, -1);
      do_read(n % 2, $urandom_range(0, 31), 0, 1'b1, -1);
    end
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1)
        do_write(d, $urandom_range(0, 31), 8'($urandom), ($urandom_range(0, 5) == 0));
      else
        do_read(d, $urandom_range(0, 31), $urandom_range(0, 7), 1'($urandom), -1);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int d = 0; d < 2; d++) begin
      do_write(d, 12, 8'h5A, 1'b0);
      do_read(d, 10, 5, 1'b0, 1);
      do_read(d, 10, 5, 1'b0, -1);
    end
  endtask

  task automatic test_parity();
    for (int d = 0; d < 2; d++) begin
      do_write(d, 7, 8'h0F, 1'b1);
      do_read(d, 7, 0, 1'b0, -1);
      do_read(d, 5, 4, 1'b0, -1);
      do_write(d, 7, 8'h0F, 1'b0);
      do_read(d, 7, 0, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single_read();
    test_wrap();
    test_long_burst();
    test_back_to_back();
    test_parity();
    test_random();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
